// File: rtl/as_imem_load_ctrl.sv
// I-Mem preload sequencer: buffers JTAG load words and owns the I-Mem write port while loading.
// Holds the core in reset until a run command drains the buffer and a fixed hold period expires.
module as_imem_load_ctrl #(
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned IW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_HOLD   = 4,
    parameter int unsigned BOOT_HOLD  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ld_valid_i,
    input  logic [IMEM_AW-1:0] ld_addr_i,
    input  logic [IW-1:0]      ld_data_i,
    input  logic               ld_we_i,
    input  logic [IMEM_AW-1:0] if_addr_i,
    input  logic               imem_busy_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [IW-1:0]      imem_wdata_o,
    output logic               imem_we_o,
    output logic               core_rst_o,
    output logic               loading_o,
    output logic [15:0]        ld_count_o,
    output logic               ld_ovf_o,
    output logic               ld_misalign_o
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef struct packed {
        logic [IMEM_AW-1:0] addr;
        logic [IW-1:0]      data;
    } entry_t;

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FLUSH, ST_RELEASE} state_t;

    state_t        state;
    state_t        state_nxt;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [HW-1:0] hold_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          aligned;
    logic          push_ok;
    logic          pop;
    logic          run_cmd;
    logic          drained;

    // Push/pop qualification; reset suppresses any write in the cycle it is asserted.
    always_comb begin
        head       = fifo_mem[rd_ptr];
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
        push_req   = ld_valid_i && ld_we_i;
        aligned    = (ld_addr_i[1:0] == 2'b00);
        run_cmd    = ld_valid_i && !ld_we_i;
        pop        = !rst_i && ((state == ST_LOAD) || (state == ST_FLUSH))
                     && !fifo_empty && !imem_busy_i;
        push_ok    = push_req && aligned && (!fifo_full || pop);
        drained    = ((fifo_cnt - CW'(pop)) == '0) && !push_ok;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= '{addr: ld_addr_i, data: ld_data_i};
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= (BOOT_HOLD != 0) ? ST_LOAD : ST_RUN;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (push_ok) state_nxt = ST_LOAD;
            ST_LOAD:    if (run_cmd) state_nxt = ST_FLUSH;
            ST_FLUSH:   if (drained) state_nxt = ST_RELEASE;
            ST_RELEASE: begin
                if (push_ok)              state_nxt = ST_LOAD;
                else if (hold_cnt == '0)  state_nxt = ST_RUN;
            end
            default:    state_nxt = state;
        endcase
    end

    // Hold counter is preloaded outside RELEASE so entry always starts at RST_HOLD-1.
    always_ff @(posedge clk_i) begin
        if (rst_i)                     hold_cnt <= '0;
        else if (state != ST_RELEASE)  hold_cnt <= HW'(RST_HOLD - 1);
        else if (hold_cnt != '0)       hold_cnt <= hold_cnt - HW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_count_o    <= '0;
            ld_ovf_o      <= 1'b0;
            ld_misalign_o <= 1'b0;
        end else begin
            if ((state == ST_RUN) && push_ok)          ld_count_o <= '0;
            else if (pop && (ld_count_o != 16'hFFFF))  ld_count_o <= ld_count_o + 16'd1;
            if (push_req && !aligned)                  ld_misalign_o <= 1'b1;
            if (push_req && aligned && fifo_full && !pop) ld_ovf_o <= 1'b1;
        end
    end

    // Output decode and I-Mem port mux
    always_comb begin
        core_rst_o   = 1'b1;
        loading_o    = 1'b0;
        imem_we_o    = 1'b0;
        imem_addr_o  = '0;
        imem_wdata_o = '0;
        case (state)
            ST_RUN: begin
                core_rst_o  = 1'b0;
                imem_addr_o = if_addr_i;
            end
            ST_LOAD, ST_FLUSH: loading_o = 1'b1;
            default: ;
        endcase
        if ((state != ST_RUN) && !fifo_empty) begin
            imem_addr_o  = head.addr;
            imem_wdata_o = head.data;
        end
        imem_we_o = pop;
    end

endmodule
